mam_wb_adapter: RTL and testbench
=================================

Name: mam_wb_adapter

Overview:
Downstream stage of osd_mam. Consumes the MAM generic memory interface (req/write/read handshakes) and executes each request as Wishbone B3 master cycles, single or incrementing burst, on the system bus. One instance per MAM memory region; sits between osd_mam and the SoC Wishbone interconnect.

Parameters:
DATA_WIDTH, 16, data word width in bits; multiple of 8.
ADDR_WIDTH, 32, byte address width.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset; asynchronous, active-high.
req_valid  in  1  MAM request valid.
req_ready  out  1  adapter accepts request.
req_rw  in  1  1=write, 0=read.
req_addr  in  ADDR_WIDTH  start byte address.
req_burst  in  1  1=burst of req_beats, 0=single beat.
req_beats  in  14  burst length in words.
write_valid  in  1  write word valid.
write_data  in  DATA_WIDTH  write word.
write_strb  in  DATA_WIDTH/8  byte enables.
write_ready  out  1  write word accepted.
read_valid  out  1  read word valid.
read_data  out  DATA_WIDTH  read word.
read_ready  in  1  MAM accepts read word.
wb_adr_o  out  ADDR_WIDTH  Wishbone byte address.
wb_dat_o  out  DATA_WIDTH  write data.
wb_sel_o  out  DATA_WIDTH/8  byte select.
wb_we_o  out  1  write enable.
wb_cyc_o  out  1  cycle.
wb_stb_o  out  1  strobe.
wb_cti_o  out  3  cycle type id.
wb_bte_o  out  2  burst type; constant 2'b00 (linear).
wb_dat_i  in  DATA_WIDTH  read data.
wb_ack_i  in  1  acknowledge.
wb_err_i  in  1  error termination.

Behaviour:
- Reset (async, active-high): state IDLE; wb_cyc_o/wb_stb_o/wb_we_o=0, wb_adr_o/wb_dat_o/wb_sel_o/wb_cti_o=0, read_valid=0, read_data=0, write_ready=0; req_ready=1 (decoded from IDLE). Reset mid-burst drops cyc/stb immediately and abandons the burst; no beat is replayed.
- States: IDLE, WR_FETCH, WR_BUS, RD_BUS, RD_HOLD.
- IDLE: req_ready=1. On req_valid: latch addr, we=req_rw, remaining = req_burst ? req_beats : 1; req_burst=1 with req_beats=0 is treated as 1 beat. Go to WR_FETCH (write) or RD_BUS (read). wb_cyc_o rises with the first strobe and stays high until the last beat terminates.
- WR_FETCH: write_ready=1. On write_valid, register write_data->wb_dat_o, write_strb->wb_sel_o; next cycle is WR_BUS with stb=1. wb_cyc_o stays high during FETCH gaps inside a burst; stb=0 there.
- WR_BUS: stb=1 until wb_ack_i or wb_err_i. On termination: remaining--, adr += DATA_WIDTH/8 (modulo 2^ADDR_WIDTH). remaining==0 -> IDLE (cyc=0 same edge), else -> WR_FETCH.
- RD_BUS: wb_sel_o all ones; stb=1 until ack/err; capture wb_dat_i->read_data and set read_valid, go to RD_HOLD. stb=0 and cyc held high while in RD_HOLD.
- RD_HOLD: read_valid=1, read_data stable until read_ready. On read_ready: remaining--, adr advances; remaining==0 -> IDLE, else -> RD_BUS.
- wb_cti_o: single request 3'b000; burst beats 3'b010 except the final beat 3'b111.
- wb_err_i terminates the beat exactly like ack (no retry). Read data is forwarded as sampled. ack and err together count as one termination.
- Minimum latency: write 2 cycles/beat with zero-wait slave; read 2 cycles/beat with read_ready=1.
- req_ready=0 outside IDLE; a new request is accepted the cycle after the last beat completes.

Decomposition:
- Shared package mam_wb_pkg: CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111), BTE_LINEAR=2'b00, state enum.
- No sub-module. Single FSM plus address register and 14-bit beat counter.

Test Plan:
- Single write addr 0x0000_0010, data 0x000f, strb 2'b11, zero-wait ack -> one WB cycle, adr 0x10, dat 0x000f, sel 2'b11, cti 000, we=1; req_ready back high 1 cycle after ack.
- Burst write 6 beats from 0x0, data 0x0001..0x0006 -> adr 0x0,0x2,...,0xA; cti 010 x5 then 111; cyc continuous; dat matches in order.
- write_valid withheld 10 cycles mid-burst -> stb=0, cyc=1 during the gap; no extra WB beat; burst completes with 4 beats after 4-beat request.
- Burst read 4 beats from 0x100, slave returns 0xA0..0xA3 with 3 wait states, read_ready low 5 cycles on beat 2 -> read_data held stable; sequence 0xA0..0xA3; stb=0 while in HOLD.
- wb_err_i on beat 2 of a 3-beat write -> beat counted, address advances to 0x4, beat 3 issued, return to IDLE.
- rst asserted during beat 3 of an 8-beat read -> cyc/stb/read_valid drop asynchronously; after release req_ready=1 and a new single read completes normally.

Source files
------------

// File: rtl/mam_wb_pkg.sv
// Shared definitions for the MAM-to-Wishbone adapter: Wishbone cycle-type
// codes, burst type, FSM state encoding and the per-beat CTI selection.
package mam_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FETCH = 3'd1,
        ST_WR_BUS   = 3'd2,
        ST_RD_BUS   = 3'd3,
        ST_RD_HOLD  = 3'd4
    } state_e;

    // Cycle type for the beat about to be strobed, given how many beats
    // (including this one) are still outstanding.
    function automatic logic [2:0] beat_cti(input logic burst, input logic [13:0] remaining);
        logic [2:0] cti;
        if (!burst) begin
            cti = CTI_CLASSIC;
        end else if (remaining == 14'd1) begin
            cti = CTI_EOB;
        end else begin
            cti = CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/mam_wb_adapter.sv
// MAM generic memory interface to Wishbone B3 master. Each MAM request is
// executed as one Wishbone cycle made of single or incrementing-burst beats.
// Every output is driven from a register; the FSM computes next values in
// one combinational process and a single sequential process stores them.
module mam_wb_adapter
    import mam_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,
    input  logic                    write_valid,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,
    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_ready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int                    BYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(BYTES);

    state_e                  state_r,       state_s;
    logic [ADDR_WIDTH-1:0]   adr_r,         adr_s;
    logic [DATA_WIDTH-1:0]   dat_r,         dat_s;
    logic [DATA_WIDTH/8-1:0] sel_r,         sel_s;
    logic                    we_r,          we_s;
    logic                    cyc_r,         cyc_s;
    logic                    stb_r,         stb_s;
    logic [2:0]              cti_r,         cti_s;
    logic                    burst_r,       burst_s;
    logic [13:0]             remaining_r,   remaining_s;
    logic [DATA_WIDTH-1:0]   read_data_r,   read_data_s;
    logic                    read_valid_r,  read_valid_s;
    logic                    write_ready_r, write_ready_s;
    logic                    req_ready_r,   req_ready_s;

    logic                    term_s;
    logic [13:0]             beats_eff_s;
    logic [13:0]             remaining_dec_s;
    logic [ADDR_WIDTH-1:0]   adr_inc_s;

    // Next-state and next-register computation for the adapter FSM.
    always_comb begin
        state_s       = state_r;
        adr_s         = adr_r;
        dat_s         = dat_r;
        sel_s         = sel_r;
        we_s          = we_r;
        cyc_s         = cyc_r;
        stb_s         = stb_r;
        cti_s         = cti_r;
        burst_s       = burst_r;
        remaining_s   = remaining_r;
        read_data_s   = read_data_r;
        read_valid_s  = read_valid_r;
        write_ready_s = write_ready_r;
        req_ready_s   = req_ready_r;

        // ack and err together are a single termination; err is not retried.
        term_s          = wb_ack_i | wb_err_i;
        // A burst request of zero beats still moves one word.
        beats_eff_s     = (req_burst && (req_beats != 14'd0)) ? req_beats : 14'd1;
        remaining_dec_s = remaining_r - 14'd1;
        adr_inc_s       = adr_r + ADR_STEP;

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    adr_s       = req_addr;
                    we_s        = req_rw;
                    burst_s     = req_burst;
                    remaining_s = beats_eff_s;
                    req_ready_s = 1'b0;
                    if (req_rw) begin
                        state_s       = ST_WR_FETCH;
                        write_ready_s = 1'b1;
                    end else begin
                        // Reads strobe straight away; cyc rises with that strobe.
                        state_s = ST_RD_BUS;
                        cyc_s   = 1'b1;
                        stb_s   = 1'b1;
                        sel_s   = '1;
                        cti_s   = beat_cti(req_burst, beats_eff_s);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WR_FETCH: begin
                if (write_valid) begin
                    state_s       = ST_WR_BUS;
                    dat_s         = write_data;
                    sel_s         = write_strb;
                    write_ready_s = 1'b0;
                    cyc_s         = 1'b1;
                    stb_s         = 1'b1;
                    cti_s         = beat_cti(burst_r, remaining_r);
                end else begin
                    // Waiting for the next word: cyc is held, stb stays low.
                    state_s = ST_WR_FETCH;
                end
            end

            ST_WR_BUS: begin
                if (term_s) begin
                    stb_s       = 1'b0;
                    remaining_s = remaining_dec_s;
                    adr_s       = adr_inc_s;
                    if (remaining_dec_s == 14'd0) begin
                        state_s     = ST_IDLE;
                        cyc_s       = 1'b0;
                        req_ready_s = 1'b1;
                    end else begin
                        state_s       = ST_WR_FETCH;
                        write_ready_s = 1'b1;
                    end
                end else begin
                    state_s = ST_WR_BUS;
                end
            end

            ST_RD_BUS: begin
                if (term_s) begin
                    state_s      = ST_RD_HOLD;
                    stb_s        = 1'b0;
                    read_data_s  = wb_dat_i;
                    read_valid_s = 1'b1;
                end else begin
                    state_s = ST_RD_BUS;
                end
            end

            ST_RD_HOLD: begin
                if (read_ready) begin
                    read_valid_s = 1'b0;
                    remaining_s  = remaining_dec_s;
                    adr_s        = adr_inc_s;
                    if (remaining_dec_s == 14'd0) begin
                        state_s     = ST_IDLE;
                        cyc_s       = 1'b0;
                        req_ready_s = 1'b1;
                    end else begin
                        state_s = ST_RD_BUS;
                        stb_s   = 1'b1;
                        cti_s   = beat_cti(burst_r, remaining_dec_s);
                    end
                end else begin
                    state_s = ST_RD_HOLD;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a quiet, idle bus.
                state_s       = ST_IDLE;
                cyc_s         = 1'b0;
                stb_s         = 1'b0;
                read_valid_s  = 1'b0;
                write_ready_s = 1'b0;
                req_ready_s   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops the bus cycle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            adr_r         <= '0;
            dat_r         <= '0;
            sel_r         <= '0;
            we_r          <= 1'b0;
            cyc_r         <= 1'b0;
            stb_r         <= 1'b0;
            cti_r         <= CTI_CLASSIC;
            burst_r       <= 1'b0;
            remaining_r   <= 14'd0;
            read_data_r   <= '0;
            read_valid_r  <= 1'b0;
            write_ready_r <= 1'b0;
            req_ready_r   <= 1'b1;
        end else begin
            state_r       <= state_s;
            adr_r         <= adr_s;
            dat_r         <= dat_s;
            sel_r         <= sel_s;
            we_r          <= we_s;
            cyc_r         <= cyc_s;
            stb_r         <= stb_s;
            cti_r         <= cti_s;
            burst_r       <= burst_s;
            remaining_r   <= remaining_s;
            read_data_r   <= read_data_s;
            read_valid_r  <= read_valid_s;
            write_ready_r <= write_ready_s;
            req_ready_r   <= req_ready_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign write_ready = write_ready_r;
    assign read_valid  = read_valid_r;
    assign read_data   = read_data_r;
    assign wb_adr_o    = adr_r;
    assign wb_dat_o    = dat_r;
    assign wb_sel_o    = sel_r;
    assign wb_we_o     = we_r;
    assign wb_cyc_o    = cyc_r;
    assign wb_stb_o    = stb_r;
    assign wb_cti_o    = cti_r;
    assign wb_bte_o    = BTE_LINEAR;

endmodule

// File: tb/tb_mam_wb_adapter.sv
// Testbench for mam_wb_adapter: Wishbone slave model with wait states and
// error injection, a MAM-side driver, and per-feature checks against
// expectations derived from the request parameters.
module tb_mam_wb_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_burst = 1'b0;
    logic [13:0] req_beats = 14'd0;
    logic        write_valid = 1'b0;
    logic [15:0] write_data = 16'd0;
    logic [1:0]  write_strb = 2'd0;
    logic        write_ready;
    logic        read_valid;
    logic [15:0] read_data;
    logic        read_ready = 1'b0;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mam_wb_adapter #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
        .write_ready(write_ready),
        .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // ---------------- Wishbone slave model ----------------
    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic        err;
    } beat_t;

    beat_t       blog[$];
    int          ws_cfg = 0;
    int          ws_cnt = 0;
    int          beat_total = 0;
    int          err_on_beat = -1;
    logic [15:0] rd_seed = 16'd0;
    logic [31:0] rd_base = 32'd0;
    logic        term_now;
    logic        cyc_q = 1'b0;
    int          cyc_rises = 0;

    function automatic beat_t mk_beat(input logic [31:0] a, input logic [15:0] d,
                                      input logic [1:0] s, input logic w,
                                      input logic [2:0] c, input logic e);
        beat_t b;
        b.adr = a; b.dat = d; b.sel = s; b.we = w; b.cti = c; b.err = e;
        return b;
    endfunction

    assign term_now = wb_cyc_o && wb_stb_o && (ws_cnt >= ws_cfg);
    assign wb_ack_i = term_now && (beat_total != err_on_beat);
    assign wb_err_i = term_now && (beat_total == err_on_beat);
    // Word k of a read returns rd_seed + k (address distance from rd_base).
    assign wb_dat_i = rd_seed + 16'((wb_adr_o - rd_base) >> 1);

    // Slave: count wait states and log every terminated beat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_cnt <= 0;
        end else if (term_now) begin
            blog.push_back(mk_beat(wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o, wb_err_i));
            ws_cnt     <= 0;
            beat_total <= beat_total + 1;
        end else if (wb_cyc_o && wb_stb_o) begin
            ws_cnt <= ws_cnt + 1;
        end else begin
            ws_cnt <= 0;
        end
    end

    // Count Wishbone cycle starts (rising cyc).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 1'b0;
        end else begin
            cyc_q <= wb_cyc_o;
            if (wb_cyc_o && !cyc_q) cyc_rises <= cyc_rises + 1;
        end
    end

    // ---------------- MAM-side driver ----------------
    logic [15:0] wq_data[$];
    logic [1:0]  wq_strb[$];
    logic [15:0] rq[$];

    task automatic drive_req(input logic rw, input logic [31:0] addr, input logic burst,
                             input logic [13:0] beats, input int gap_at, input int gap_len,
                             input int stall_at, input int stall_len,
                             output int viol, output int done_lat, output logic timeout);
        int n;
        int guard;
        logic [15:0] held;
        viol = 0; done_lat = 0; timeout = 1'b0;
        n = (burst && beats != 14'd0) ? int'(beats) : 1;
        guard = 0;
        while (!req_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!req_ready) begin timeout = 1'b1; return; end
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_burst = burst; req_beats = beats;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (rw) begin
                if (k == gap_at) begin
                    for (int g = 0; g < gap_len; g++) begin
                        if (write_ready && (wb_stb_o || !wb_cyc_o)) viol++;
                        @(posedge clk); #1;
                    end
                end
                write_valid = 1'b1; write_data = wq_data[k]; write_strb = wq_strb[k];
                guard = 0;
                while (!write_ready && guard < 200) begin @(posedge clk); #1; guard++; end
                if (!write_ready) begin timeout = 1'b1; write_valid = 1'b0; return; end
                @(posedge clk); #1;
                write_valid = 1'b0;
            end else begin
                guard = 0;
                while (!read_valid && guard < 200) begin @(posedge clk); #1; guard++; end
                if (!read_valid) begin timeout = 1'b1; return; end
                if (k == stall_at) begin
                    held = read_data;
                    for (int g = 0; g < stall_len; g++) begin
                        if (!read_valid || read_data !== held || wb_stb_o || !wb_cyc_o) viol++;
                        @(posedge clk); #1;
                    end
                end
                rq.push_back(read_data);
                read_ready = 1'b1;
                @(posedge clk); #1;
                read_ready = 1'b0;
            end
        end
        guard = 0;
        while (!req_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        done_lat = guard;
        if (!req_ready) timeout = 1'b1;
    endtask

    // ---------------- Feature tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        #3;
        checks++;
        if ({req_ready, write_ready, read_valid, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {req_ready, write_ready, read_valid, wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, read_data} !== 69'd0) begin
            errors++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%b cti=%b rdata=%h want all 0",
                     wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, read_data);
        end
        checks++;
        if (wb_bte_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_bte: got %b want 00", wb_bte_o);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int v, lat, b0, r0;
        logic to;
        ws_cfg = 0;
        wq_data = '{16'h000f}; wq_strb = '{2'b11};
        b0 = blog.size(); r0 = cyc_rises;
        drive_req(1'b1, 32'h0000_0010, 1'b0, 14'd0, -1, 0, -1, 0, v, lat, to);
        checks++;
        if (to || blog.size() - b0 != 1) begin
            errors++;
            $display("FAIL single_write_count: timeout=%0d beats=%0d want 0/1", to, blog.size() - b0);
        end else begin
            checks++;
            if ({blog[b0].adr, blog[b0].dat, blog[b0].sel, blog[b0].cti, blog[b0].we}
                !== {32'h10, 16'h000f, 2'b11, 3'b000, 1'b1}) begin
                errors++;
                $display("FAIL single_write_beat: adr=%h dat=%h sel=%b cti=%b we=%b want 10/000f/11/000/1",
                         blog[b0].adr, blog[b0].dat, blog[b0].sel, blog[b0].cti, blog[b0].we);
            end
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL single_write_ready_lat: got %0d want 1", lat);
        end
        checks++;
        if (cyc_rises - r0 != 1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_write_cyc: cycles=%0d cyc=%b want 1/0", cyc_rises - r0, wb_cyc_o);
        end
    endtask

    task automatic test_burst_write();
        int v, lat, b0, r0;
        logic to;
        ws_cfg = 0;
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < 6; k++) begin wq_data.push_back(16'(k + 1)); wq_strb.push_back(2'b11); end
        b0 = blog.size(); r0 = cyc_rises;
        drive_req(1'b1, 32'h0, 1'b1, 14'd6, -1, 0, -1, 0, v, lat, to);
        checks++;
        if (to || blog.size() - b0 != 6) begin
            errors++;
            $display("FAIL burst_write_count: timeout=%0d beats=%0d want 0/6", to, blog.size() - b0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                logic [2:0] ecti;
                ecti = (k == 5) ? 3'b111 : 3'b010;
                checks++;
                if ({blog[b0+k].adr, blog[b0+k].dat, blog[b0+k].cti, blog[b0+k].we}
                    !== {32'(2 * k), 16'(k + 1), ecti, 1'b1}) begin
                    errors++;
                    $display("FAIL burst_write_beat%0d: adr=%h dat=%h cti=%b want %h/%h/%b",
                             k, blog[b0+k].adr, blog[b0+k].dat, blog[b0+k].cti, 32'(2 * k), 16'(k + 1), ecti);
                end
            end
        end
        checks++;
        if (cyc_rises - r0 != 1) begin
            errors++;
            $display("FAIL burst_write_cyc_continuous: cycles=%0d want 1", cyc_rises - r0);
        end
    endtask

    task automatic test_write_gap();
        int v, lat, b0;
        logic to;
        ws_cfg = 0;
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < 4; k++) begin wq_data.push_back(16'($urandom)); wq_strb.push_back(2'($urandom)); end
        b0 = blog.size();
        drive_req(1'b1, 32'h40, 1'b1, 14'd4, 2, 10, -1, 0, v, lat, to);
        checks++;
        if (to || v != 0) begin
            errors++;
            $display("FAIL write_gap_bus: timeout=%0d gap_violations=%0d want 0/0", to, v);
        end
        checks++;
        if (blog.size() - b0 != 4) begin
            errors++;
            $display("FAIL write_gap_count: beats=%0d want 4", blog.size() - b0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({blog[b0+k].dat, blog[b0+k].sel} !== {wq_data[k], wq_strb[k]}) begin
                    errors++;
                    $display("FAIL write_gap_data%0d: got %h/%b want %h/%b",
                             k, blog[b0+k].dat, blog[b0+k].sel, wq_data[k], wq_strb[k]);
                end
            end
        end
    endtask

    task automatic test_burst_read();
        int v, lat, b0;
        logic to;
        ws_cfg = 3; rd_base = 32'h100; rd_seed = 16'h00A0;
        rq.delete();
        b0 = blog.size();
        drive_req(1'b0, 32'h100, 1'b1, 14'd4, -1, 0, 1, 5, v, lat, to);
        checks++;
        if (to || v != 0 || rq.size() != 4) begin
            errors++;
            $display("FAIL burst_read_hold: timeout=%0d hold_violations=%0d words=%0d want 0/0/4",
                     to, v, rq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rq[k] !== 16'(16'h00A0 + k)) begin
                    errors++;
                    $display("FAIL burst_read_word%0d: got %h want %h", k, rq[k], 16'(16'h00A0 + k));
                end
            end
        end
        checks++;
        if (blog.size() - b0 != 4 ||
            {blog[b0+3].adr, blog[b0+3].sel, blog[b0+3].we, blog[b0+3].cti} !== {32'h106, 2'b11, 1'b0, 3'b111}) begin
            errors++;
            $display("FAIL burst_read_lastbeat: beats=%0d want 4 ending adr 106 sel 11 we 0 cti 111",
                     blog.size() - b0);
        end
        ws_cfg = 0;
    endtask

    task automatic test_err_write();
        int v, lat, b0;
        logic to;
        ws_cfg = 0;
        wq_data = '{16'h1111, 16'h2222, 16'h3333}; wq_strb = '{2'b11, 2'b01, 2'b10};
        b0 = blog.size();
        err_on_beat = beat_total + 1;
        drive_req(1'b1, 32'h0, 1'b1, 14'd3, -1, 0, -1, 0, v, lat, to);
        err_on_beat = -1;
        checks++;
        if (to || blog.size() - b0 != 3) begin
            errors++;
            $display("FAIL err_write_count: timeout=%0d beats=%0d want 0/3", to, blog.size() - b0);
        end else begin
            checks++;
            if ({blog[b0+1].err, blog[b0+1].adr, blog[b0+2].adr, blog[b0+2].dat, blog[b0+2].cti}
                !== {1'b1, 32'h2, 32'h4, 16'h3333, 3'b111}) begin
                errors++;
                $display("FAIL err_write_advance: err=%b adr2=%h adr3=%h dat3=%h cti3=%b want 1/2/4/3333/111",
                         blog[b0+1].err, blog[b0+1].adr, blog[b0+2].adr, blog[b0+2].dat, blog[b0+2].cti);
            end
        end
        checks++;
        if (req_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL err_write_idle: req_ready=%b cyc=%b want 1/0", req_ready, wb_cyc_o);
        end
    endtask

    task automatic test_reset_mid_read();
        int v, lat, b0, b1, guard;
        logic to;
        ws_cfg = 2; rd_base = 32'h300; rd_seed = 16'h0010;
        b0 = beat_total;
        guard = 0;
        while (!req_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h300; req_burst = 1'b1; req_beats = 14'd8;
        @(posedge clk); #1;
        req_valid = 1'b0; read_ready = 1'b1;
        guard = 0;
        while (!(beat_total - b0 >= 2 && wb_stb_o) && guard < 200) begin @(posedge clk); #1; guard++; end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL rst_mid_read_reach: beat 3 not reached within 200 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, read_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_read_drop: cyc/stb/rvalid/req_ready=%b want 0001",
                     {wb_cyc_o, wb_stb_o, read_valid, req_ready});
        end
        read_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ws_cfg = 0; rd_base = 32'h200; rd_seed = 16'h0055;
        rq.delete();
        b1 = blog.size();
        drive_req(1'b0, 32'h200, 1'b0, 14'd5, -1, 0, -1, 0, v, lat, to);
        checks++;
        if (to || rq.size() != 1 || rq[0] !== 16'h0055 || blog.size() - b1 != 1) begin
            errors++;
            $display("FAIL rst_mid_read_after: timeout=%0d words=%0d data=%h beats=%0d want 0/1/0055/1",
                     to, rq.size(), (rq.size() > 0) ? rq[0] : 16'hxxxx, blog.size() - b1);
        end else begin
            checks++;
            if ({blog[b1].adr, blog[b1].cti} !== {32'h200, 3'b000}) begin
                errors++;
                $display("FAIL rst_mid_read_beat: adr=%h cti=%b want 200/000", blog[b1].adr, blog[b1].cti);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic        rw, burst, to;
            logic [31:0] addr;
            logic [13:0] beats;
            int n, b0, v, lat, gap_at, stall_at, bad;
            rw    = 1'($urandom_range(0, 1));
            addr  = $urandom & 32'hFFFF_FFFE;
            burst = 1'($urandom_range(0, 1));
            beats = 14'($urandom_range(0, 6));
            if (it == 0) begin addr = 32'hFFFF_FFFC; burst = 1'b1; beats = 14'd4; end
            if (it == 1) begin burst = 1'b1; beats = 14'd0; end
            n = (burst && beats != 14'd0) ? int'(beats) : 1;
            ws_cfg = $urandom_range(0, 2);
            rd_base = addr; rd_seed = 16'($urandom);
            wq_data.delete(); wq_strb.delete(); rq.delete();
            for (int k = 0; k < n; k++) begin wq_data.push_back(16'($urandom)); wq_strb.push_back(2'($urandom)); end
            gap_at   = $urandom_range(1, n);
            stall_at = $urandom_range(0, n);
            b0 = blog.size();
            drive_req(rw, addr, burst, beats, gap_at, $urandom_range(0, 3), stall_at,
                      $urandom_range(0, 3), v, lat, to);
            checks++;
            if (to || v != 0 || blog.size() - b0 != n || (!rw && rq.size() != n)) begin
                errors++;
                $display("FAIL rand%0d_shape: timeout=%0d viol=%0d beats=%0d words=%0d want 0/0/%0d",
                         it, to, v, blog.size() - b0, rq.size(), n);
            end else begin
                bad = 0;
                for (int k = 0; k < n; k++) begin
                    logic [2:0]  ecti;
                    logic [31:0] eadr;
                    ecti = !burst ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
                    eadr = addr + 32'(2 * k);
                    if (blog[b0+k].adr !== eadr || blog[b0+k].cti !== ecti || blog[b0+k].we !== rw) bad++;
                    if (rw && {blog[b0+k].dat, blog[b0+k].sel} !== {wq_data[k], wq_strb[k]}) bad++;
                    if (!rw && (blog[b0+k].sel !== 2'b11 || rq[k] !== 16'(rd_seed + 16'(k)))) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand%0d_beats: rw=%b addr=%h burst=%b beats=%0d wrong_fields=%0d want 0",
                             it, rw, addr, burst, beats, bad);
                end
            end
        end
        ws_cfg = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_write_gap();
        test_burst_read();
        test_err_write();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
